// File: rtl/data_read_arbiter_pkg.sv
// Shared read-path types for the data storage arbiter and its tracking FIFO.
package DataInterface_pkg;

  typedef struct packed {
    logic [7:0]  request_id;
    logic [7:0]  receive_id;
    logic [31:0] read_address;
  } read_request_t;

  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] half;
  } data_register_union_t;

  typedef logic [3:0] arb_channel_t;

  typedef struct packed {
    arb_channel_t  channel;
    read_request_t request;
  } read_track_entry_t;

  localparam int DefaultMaxOutstanding = 8;

endpackage

// File: rtl/data_read_arbiter_track_fifo.sv
// In-order tracker of accepted reads: which channel issued each outstanding request.
module read_track_fifo
  import DataInterface_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  read_track_entry_t         push_entry_i,
  input  logic                      pop_i,
  output read_track_entry_t         head_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q;
  read_track_entry_t mem_q [DEPTH];

  // Storage needs no reset; occupancy is governed solely by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/data_read_arbiter.sv
// Round-robin arbiter sharing the storage read port; routes in-order responses back.
// Optional READ_ARB_TRACE_EN adds simulation-only debuglogger calls.
module data_read_arbiter
  import DataInterface_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int MAX_OUTSTANDING = DefaultMaxOutstanding
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            req_valid,
  output logic [NUM_CHANNELS-1:0]            req_ready,
  input  read_request_t                      req [NUM_CHANNELS],
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output read_request_t                      mem_req,
  input  logic                               mem_rsp_valid,
  input  data_register_union_t               mem_rsp_data,
  output logic [NUM_CHANNELS-1:0]            rsp_valid,
  output read_request_t                      rsp_req,
  output data_register_union_t               rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               rsp_err
);

  localparam int CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic                    gnt_valid;
  arb_channel_t            gnt_ch;
  read_request_t           gnt_req;
  logic                    accept, fifo_pop, slot_free, room;
  read_track_entry_t       push_entry, head;
  logic [CntW-1:0]         count;

  arb_channel_t            last_grant_q, last_grant_d;
  logic                    mem_req_valid_q, mem_req_valid_d;
  read_request_t           mem_req_q, mem_req_d;
  logic [NUM_CHANNELS-1:0] rsp_valid_q, rsp_valid_d;
  read_request_t           rsp_req_q, rsp_req_d;
  data_register_union_t    rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;

  // Two passes: channels above last_grant first, then wrap to the low ones.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    gnt_req   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!gnt_valid && req_valid[i] && (arb_channel_t'(i) > last_grant_q)) begin
        gnt_valid = 1'b1;
        gnt_ch    = arb_channel_t'(i);
        gnt_req   = req[i];
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!gnt_valid && req_valid[i] && (arb_channel_t'(i) <= last_grant_q)) begin
        gnt_valid = 1'b1;
        gnt_ch    = arb_channel_t'(i);
        gnt_req   = req[i];
      end
    end
  end

  assign slot_free = !mem_req_valid_q || mem_req_ready;
  assign room      = (count < CntW'(MAX_OUTSTANDING)) || mem_rsp_valid;
  assign accept    = rst_n && gnt_valid && slot_free && room;
  assign fifo_pop  = mem_rsp_valid && (count != '0);

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      req_ready[i] = accept && (gnt_ch == arb_channel_t'(i));
    end
  end

  assign push_entry = '{channel: gnt_ch, request: gnt_req};

  read_track_fifo #(.DEPTH(MAX_OUTSTANDING)) u_track (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (head),
    .count_o      (count)
  );

  always_comb begin
    last_grant_d    = last_grant_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_d       = mem_req_q;
    if (accept) begin
      mem_req_valid_d = 1'b1;
      mem_req_d       = gnt_req;
      last_grant_d    = gnt_ch;
    end else if (mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    rsp_req_d  = rsp_req_q;
    rsp_data_d = rsp_data_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rsp_valid_d[i] = fifo_pop && (head.channel == arb_channel_t'(i));
    end
    if (fifo_pop) begin
      rsp_req_d  = head.request;
      rsp_data_d = mem_rsp_data;
    end
    // A response with nothing in flight is dropped but remembered.
    rsp_err_d = rsp_err_q || (mem_rsp_valid && !fifo_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q    <= arb_channel_t'(NUM_CHANNELS - 1);
      mem_req_valid_q <= 1'b0;
      mem_req_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_req_q       <= '0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      last_grant_q    <= last_grant_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_q       <= mem_req_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_req_q       <= rsp_req_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req       = mem_req_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_req       = rsp_req_q;
  assign rsp_data      = rsp_data_q;
  assign outstanding   = count;
  assign rsp_err       = rsp_err_q;

`ifdef READ_ARB_TRACE_EN
  always @(posedge clk) begin
    if (accept)   debuglogger::log_read_request(gnt_req, gnt_ch);
    if (fifo_pop) debuglogger::log_read_complete(head.request);
  end
`endif

endmodule

// File: tb/tb_data_read_arbiter.sv
// Self-checking bench: cycle model of arbitration plus an in-order response scoreboard.
module tb_data_read_arbiter;
  import DataInterface_pkg::*;

  localparam int NCH  = 4;
  localparam int MAXO = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       req_valid, req_ready;
  read_request_t        req [NCH];
  logic                 mem_req_valid, mem_req_ready;
  read_request_t        mem_req;
  logic                 mem_rsp_valid;
  data_register_union_t mem_rsp_data;
  logic [NCH-1:0]       rsp_valid;
  read_request_t        rsp_req;
  data_register_union_t rsp_data;
  logic [3:0]           outstanding;
  logic                 rsp_err;

  always #5 clk = ~clk;

  data_read_arbiter #(.NUM_CHANNELS(NCH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .rsp_valid(rsp_valid),
    .rsp_req(rsp_req), .rsp_data(rsp_data), .outstanding(outstanding), .rsp_err(rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            ch;
    read_request_t r;
  } track_t;

  track_t         exp_q[$];
  int             m_last;
  bit             m_slot_v;
  read_request_t  m_slot;
  logic [NCH-1:0] m_rspv;
  read_request_t  m_rsp_req;
  logic [31:0]    m_rsp_data;
  bit             m_err;
  logic [NCH-1:0] last_ready;
  logic [2:0]     hs_hist;
  int             n_acc;
  logic [7:0]     id_ctr;

  function automatic void m_reset();
    exp_q.delete();
    m_last     = NCH - 1;
    m_slot_v   = 1'b0;
    m_slot     = '0;
    m_rspv     = '0;
    m_rsp_req  = '0;
    m_rsp_data = '0;
    m_err      = 1'b0;
    hs_hist    = '0;
  endfunction

  task automatic set_req(input int ch, input logic [31:0] addr);
    req[ch] = '{request_id: id_ctr, receive_id: 8'(ch), read_address: addr};
    id_ctr++;
  endtask

  // Called at a falling edge with inputs already driven for the next rising edge.
  task automatic cycle();
    int             gnt;
    bit             acc, pop, hs;
    logic [NCH-1:0] exp_rdy;
    track_t         e;
    #1;
    gnt = -1;
    for (int k = 1; k <= NCH; k++) begin
      if (gnt < 0 && req_valid[(m_last + k) % NCH]) gnt = (m_last + k) % NCH;
    end
    acc = (gnt >= 0) && (!m_slot_v || mem_req_ready) && (exp_q.size() < MAXO || mem_rsp_valid);
    exp_rdy = '0;
    if (acc) exp_rdy[gnt] = 1'b1;
    last_ready = req_ready;
    chk_eq("req_ready", req_ready, exp_rdy);

    hs  = m_slot_v && mem_req_ready;
    pop = mem_rsp_valid && (exp_q.size() > 0);
    m_rspv = '0;
    if (mem_rsp_valid && exp_q.size() == 0) m_err = 1'b1;
    if (pop) begin
      e = exp_q.pop_front();
      m_rspv[e.ch] = 1'b1;
      m_rsp_req    = e.r;
      m_rsp_data   = mem_rsp_data.word;
    end
    if (acc) begin
      e.ch = gnt;
      e.r  = req[gnt];
      exp_q.push_back(e);
      m_slot   = req[gnt];
      m_slot_v = 1'b1;
      m_last   = gnt;
      n_acc++;
    end else if (mem_req_ready) begin
      m_slot_v = 1'b0;
    end
    hs_hist = {hs_hist[1:0], hs};

    @(posedge clk);
    @(negedge clk);
    chk_eq("mem_req_valid", mem_req_valid, m_slot_v);
    chk_eq("mem_req", mem_req, m_slot);
    chk_eq("rsp_valid", rsp_valid, m_rspv);
    chk_eq("rsp_req", rsp_req, m_rsp_req);
    chk_eq("rsp_data", rsp_data, m_rsp_data);
    chk_eq("outstanding", outstanding, exp_q.size());
    chk_eq("rsp_err", rsp_err, m_err);
  endtask

  task automatic reset_and_check(input string tag);
    rst_n     = 1'b0;
    req_valid = '1;
    m_reset();
    #1;
    chk_eq({tag, "_req_ready"}, req_ready, 0);
    chk_eq({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk_eq({tag, "_mem_req"}, mem_req, 0);
    chk_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    chk_eq({tag, "_rsp_req"}, rsp_req, 0);
    chk_eq({tag, "_outstanding"}, outstanding, 0);
    chk_eq({tag, "_rsp_err"}, rsp_err, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    req_valid = '0;
    while (exp_q.size() > 0 && guard < 50) begin
      mem_rsp_valid     = 1'b1;
      mem_rsp_data.word = $urandom;
      cycle();
      guard++;
    end
    mem_rsp_valid = 1'b0;
    chk_eq("drain_outstanding", outstanding, 0);
  endtask

  initial begin
    logic [3:0]    exp_g;
    read_request_t held;
    int            guard;

    rst_n         = 1'b0;
    req_valid     = '0;
    for (int i = 0; i < NCH; i++) req[i] = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    id_ctr        = 8'd1;
    n_acc         = 0;
    m_reset();
    @(negedge clk);
    reset_and_check("por");

    // Single request on channel 2
    set_req(2, 32'h10);
    req_valid     = 4'b0100;
    mem_req_ready = 1'b1;
    cycle();
    chk_eq("single_addr", mem_req.read_address, 32'h10);
    chk_eq("single_valid", mem_req_valid, 1);
    req_valid = '0;
    cycle();
    mem_rsp_valid     = 1'b1;
    mem_rsp_data.word = 32'hABCD;
    cycle();
    chk_eq("single_rsp_valid", rsp_valid, 4'b0100);
    chk_eq("single_rsp_data", rsp_data.word, 32'hABCD);
    chk_eq("single_rsp_id", rsp_req.request_id, 8'd1);
    mem_rsp_valid = 1'b0;
    cycle();

    // Fairness from a fresh reset, then fill to the outstanding limit
    reset_and_check("rst2");
    mem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1111;
      for (int ch = 0; ch < NCH; ch++) set_req(ch, 32'h100 + 32'(c * 16 + ch));
      cycle();
      exp_g = 4'b0001 << (c % 4);
      chk_eq("fair_grant", last_ready, exp_g);
    end
    req_valid = 4'b0001;
    set_req(0, 32'h200);
    cycle();
    chk_eq("full_ready", last_ready, 0);
    chk_eq("full_outstanding", outstanding, 8);
    mem_rsp_valid     = 1'b1;
    mem_rsp_data.word = 32'h5555_0001;
    cycle();
    chk_eq("full_accept", last_ready, 4'b0001);
    chk_eq("full_out_stays", outstanding, 8);
    mem_rsp_valid = 1'b0;
    drain();

    // Backpressure: slot must hold while storage stalls
    mem_req_ready = 1'b0;
    req_valid     = 4'b1010;
    set_req(1, 32'h300);
    set_req(3, 32'h310);
    cycle();
    held = mem_req;
    chk_eq("bp_first_ch", last_ready, 4'b0010);
    for (int c = 0; c < 4; c++) begin
      set_req(1, 32'h320 + 32'(c));
      set_req(3, 32'h330 + 32'(c));
      cycle();
      chk_eq("bp_stable", mem_req, held);
      chk_eq("bp_ready", last_ready, 0);
    end
    mem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(1, 32'h340 + 32'(c));
      set_req(3, 32'h350 + 32'(c));
      cycle();
    end
    req_valid = '0;
    cycle();
    drain();

    // Ordering and pointer wrap with responses lagging the storage handshake by 3
    n_acc   = 0;
    hs_hist = '0;
    guard   = 0;
    while (!(n_acc >= 20 && exp_q.size() == 0 && !m_slot_v) && guard < 300) begin
      if (n_acc < 20) begin
        req_valid = 4'($urandom_range(1, 15));
        for (int ch = 0; ch < NCH; ch++) set_req(ch, $urandom);
      end else begin
        req_valid = '0;
      end
      mem_req_ready     = ($urandom_range(0, 3) != 0);
      mem_rsp_valid     = hs_hist[2];
      mem_rsp_data.word = $urandom;
      cycle();
      guard++;
    end
    req_valid     = '0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    chk_eq("wrap_drained", outstanding, 0);
    cycle();

    // Reset with three in flight, then a stray response
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      for (int ch = 0; ch < NCH; ch++) set_req(ch, 32'h400 + 32'(c * 4 + ch));
      cycle();
    end
    req_valid = '0;
    cycle();
    chk_eq("pre_rst_outstanding", outstanding, 3);
    reset_and_check("midrst");
    mem_rsp_valid     = 1'b1;
    mem_rsp_data.word = 32'hDEAD;
    cycle();
    chk_eq("err_set", rsp_err, 1);
    chk_eq("err_no_rsp", rsp_valid, 0);
    mem_rsp_valid = 1'b0;
    cycle();
    chk_eq("err_sticky", rsp_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_read_arbiter.md
# data_read_arbiter

Round-robin arbiter that shares the single data-storage read port among `NUM_CHANNELS` thread-side read requesters. It registers the granted `read_request_t` toward storage and tracks every outstanding request in order. Each returned word is routed back to the channel that issued it. It sits between the thread execution units and the data storage array.

## Interface
Parameters:
- `NUM_CHANNELS`, 4: number of requesting channels, 2..16.
- `MAX_OUTSTANDING`, 8: maximum accepted but not yet answered requests, a power of two, 2..64.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NUM_CHANNELS`: per-channel request valid.
- `req_ready` out `NUM_CHANNELS`: per-channel accept, at most one bit high.
- `req` in `NUM_CHANNELS` × `read_request_t`: per-channel request (`request_id`, `receive_id`, `read_address`).
- `mem_req_valid` out 1: request to storage is valid.
- `mem_req_ready` in 1: storage accepts the request.
- `mem_req` out `read_request_t`: registered request to storage.
- `mem_rsp_valid` in 1: storage returns one word, in request order.
- `mem_rsp_data` in `data_register_union_t`: returned word.
- `rsp_valid` out `NUM_CHANNELS`: one-cycle, one-hot return pulse.
- `rsp_req` out `read_request_t`: the request being answered.
- `rsp_data` out `data_register_union_t`: the returned word.
- `outstanding` out `$clog2(MAX_OUTSTANDING)+1`: current in-flight count.
- `rsp_err` out 1: sticky flag for a response received with nothing outstanding.

## Operation
Arbitration:
- The grant is combinational and round-robin.
- Search starts at `last_grant+1` mod `NUM_CHANNELS` and the first valid channel wins.
- `last_grant` updates only on an accepted handshake.

Acceptance:
- `req_ready[g]` is high only when all three hold:
  - channel g holds the grant;
  - the output slot is empty, or it is draining this cycle (`mem_req_valid && mem_req_ready`);
  - `outstanding < MAX_OUTSTANDING`, or `mem_rsp_valid` is high this cycle.

Accept effects:
- The request is loaded into the output slot.
- `{channel, request}` is pushed into the tracking FIFO.
- `outstanding` increments.

Output slot:
- It holds its value while `mem_req_valid && !mem_req_ready`.
- `mem_req` is stable during a stall.

Response:
- `mem_rsp_valid` pops the FIFO head.
- Outputs are registered: `rsp_valid[head.channel]`, `rsp_req=head.request`, `rsp_data=mem_rsp_data`.
- `outstanding` decrements.
- Accept and response in the same cycle leave `outstanding` unchanged.

Error case:
- `mem_rsp_valid` while `outstanding==0` is dropped, and `rsp_err` is set.
- `rsp_err` is cleared only by reset.

Wrap-around:
- FIFO pointers are `$clog2(MAX_OUTSTANDING)` bits and wrap naturally.
- Full and empty are derived from `outstanding`.

## Timing
- Reset values: all outputs 0, `req_ready` 0 during reset, `last_grant = NUM_CHANNELS-1` so channel 0 has first priority, FIFO empty.
- Request path: a handshake at edge t gives `mem_req_valid` high after t, so there is 1 cycle of latency.
- Throughput: 1 request/cycle with `mem_req_ready` held high.
- Response path: `mem_rsp_valid` at edge r gives `rsp_valid` high for exactly one cycle after r.
- No backpressure on responses.
- Reset mid-operation discards the output slot and all in-flight entries, and clears `outstanding`.
- Responses arriving after reset are treated as the error case.

## Configuration
- `READ_ARB_TRACE_EN` defined:
  - each accepted request calls `debuglogger::log_read_request(request, channel)`;
  - each response calls `debuglogger::log_read_complete(head.request)`, in simulation only.
- Without the macro there is no logging code and behaviour is cycle-identical.

## Structure
- `DataInterface_pkg` gains:
  - typedef `arb_channel_t` (`logic [3:0]`);
  - typedef `read_track_entry_t {arb_channel_t channel; read_request_t request;}`;
  - constant `DefaultMaxOutstanding = 8`.
- One sub-module, `read_track_fifo`: synchronous FIFO of `read_track_entry_t`, depth `MAX_OUTSTANDING`, with push/pop/count.
- Arbitration and the output slot stay in the top module.

## Test plan
- Single request: ch2 requests address 0x10 and `mem_req_ready` is held at 1. Required: `mem_req.read_address=0x10` one cycle later. A response of 0xABCD then gives `rsp_valid=4'b0100` and `rsp_data=0xABCD`.
- Fairness: all four channels are held valid for 8 cycles. Required: grants follow 0,1,2,3,0,1,2,3.
- Backpressure: `mem_req_ready=0` for 5 cycles. Required: `mem_req` is stable, all `req_ready` are 0 after the slot fills, and nothing is lost.
- Full limit: 8 requests with no responses. Required: `outstanding=8` and `req_ready=0`. A response plus a new request in the same cycle is accepted, and `outstanding` stays 8.
- Ordering and wrap: 20 requests interleaved across channels with responses lagging by 3 cycles. Required: each response returns on the originating channel with matching `request_id`.
- Reset and error: assert `rst_n` low with 3 outstanding. Required: everything clears to 0. A later `mem_rsp_valid` sets `rsp_err=1` and produces no `rsp_valid`.
